// File: rtl/mic_mul_seq.sv
// Shift-and-add 16x16 multiplier (low half) that time-shares
// an external mic_alu for every add and every doubling step.
module mic_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DBL,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  assign busy = (state == ADD) || (state == DBL);

  // Idle/done park the ALU on its constant-zero function.
  always_comb begin
    alu_x = '0;
    alu_y = '0;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b101010;
    unique case (state)
      IDLE, DONE: begin
      end
      ADD: begin
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b000010;
        alu_x = acc;
        alu_y = mcand;
      end
      DBL: begin
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b000010;
        alu_x = mcand;
        alu_y = mcand;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            state  <= (b == '0) ? DONE : ADD;
          end
        end
        ADD: begin
          if (mplier[0]) acc <= alu_out;
          state <= DBL;
        end
        DBL: begin
          mcand  <= alu_out;
          mplier <= mplier >> 1;
          // Remaining multiplier bits double as the loop counter.
          state  <= (mplier[WIDTH-1:1] == '0) ? DONE : ADD;
        end
        DONE: begin
          result <= acc;
          done   <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic_mul_seq.sv
// Bench for mic_mul_seq: behavioural ALU plus a product/latency
// reference model, directed cases followed by random operands.
module tb_mic_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx;
  logic        alu_nx;
  logic        alu_zy;
  logic        alu_ny;
  logic        alu_f;
  logic        alu_no;
  logic [15:0] alu_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mic_mul_seq #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .alu_x  (alu_x),
    .alu_y  (alu_y),
    .alu_zx (alu_zx),
    .alu_nx (alu_nx),
    .alu_zy (alu_zy),
    .alu_ny (alu_ny),
    .alu_f  (alu_f),
    .alu_no (alu_no),
    .alu_out(alu_out)
  );

  // Hack-style ALU standing in for mic_alu.
  always_comb begin
    logic [15:0] xx;
    logic [15:0] yy;
    logic [15:0] oo;
    xx = alu_zx ? 16'h0 : alu_x;
    if (alu_nx) xx = ~xx;
    yy = alu_zy ? 16'h0 : alu_y;
    if (alu_ny) yy = ~yy;
    oo = alu_f ? (xx + yy) : (xx & yy);
    if (alu_no) oo = ~oo;
    alu_out = oo;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ctrl();
    return {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
  endfunction

  function automatic int ref_lat(input logic [15:0] bb);
    int k = 0;
    for (int i = 0; i < 16; i++)
      if (bb[i]) k = i + 1;
    return 1 + 2 * k;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [15:0] aa,
                                           input logic [15:0] bb);
    int unsigned p;
    p = 32'(aa) * 32'(bb);
    return p[15:0];
  endfunction

  task automatic run_mul(input logic [15:0] ia, input logic [15:0] ib,
                         input bit noise);
    logic [15:0] prev;
    int          n;
    int          nbusy;
    bit          seen;
    prev = result;
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    nbusy = busy ? 1 : 0;
    seen  = 1'b0;
    n     = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) begin
        chk("ctl_busy", {26'h0, ctrl()}, 32'h02);
        nbusy++;
      end else begin
        chk("ctl_idle", {26'h0, ctrl()}, 32'h2A);
        chk("alu_xy0", {alu_x, alu_y}, 32'h0);
      end
      chk("result_held", result, prev);
      if (noise) begin
        start = 1'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
      end
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
    if (seen) begin
      chk("latency", n, ref_lat(ib));
      chk("busy_cycles", nbusy, ref_lat(ib) - 1);
      chk("product", result, ref_prod(ia, ib));
      @(posedge clk);
      #1;
      chk("done_pulse", done, 1'b0);
      chk("result_after", result, ref_prod(ia, ib));
      chk("idle_busy", busy, 1'b0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'h0);
    chk("rst_ctl", {26'h0, ctrl()}, 32'h2A);
    rst = 1'b0;

    run_mul(16'h1234, 16'h0000, 1'b0);
    run_mul(16'd3, 16'd5, 1'b0);
    run_mul(16'hFFFD, 16'd7, 1'b0);
    run_mul(16'd300, 16'd300, 1'b0);
    run_mul(16'hFFFF, 16'hFFFF, 1'b1);

    // Abort a long multiply with reset mid-flight.
    @(negedge clk);
    start = 1'b1;
    a     = 16'd3;
    b     = 16'h8000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 16'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("abort_nodone", done, 1'b0);
    end
    run_mul(16'd2, 16'd2, 1'b0);

    for (int t = 0; t < 20; t++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom >> $urandom_range(16, 32));
      run_mul(ra, rb, t[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_mul_seq.md
Name: mic_mul_seq

Overview:
- Multi-cycle sequencer that computes a 16x16 -> 16-bit product (low half) by shift-and-add.
- Does not contain an adder of its own. It time-shares one external mic_alu instance by driving that ALU's x/y operands and its six control bits, and latching the ALU's out.
- Sits between the instruction decode/execute logic and the ALU. It gives the core a MUL operation with a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width; must match mic_alu (only 16 supported).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  16  multiplicand, captured on accepted start
- b  input  16  multiplier, captured on accepted start
- busy  output  1  high while the operation is in progress (ADD/DBL states)
- done  output  1  one-cycle pulse when result is updated
- result  output  16  product low 16 bits; held until the next done
- alu_x  output  16  to mic_alu x
- alu_y  output  16  to mic_alu y
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  to mic_alu control inputs
- alu_out  input  16  from mic_alu out (combinational, same cycle)

Behaviour:
- Registers:
  - acc[15:0], mcand[15:0], mplier[15:0], state, result[15:0].
  - No other state; the bit count is implicit in mplier.
- States: IDLE, ADD, DBL, DONE.
- Reset (rst=1 at clk edge, any state, including mid-operation):
  - state=IDLE; acc, mcand, mplier, result=0.
  - busy=0, done=0. No done pulse is produced for an aborted operation.
- IDLE:
  - ALU controls = ZERO function: zx=1, nx=0, zy=1, ny=0, f=1, no=0; alu_x=alu_y=0.
  - If start=1: acc<=0, mcand<=a, mplier<=b; next = (b==0) ? DONE : ADD.
- ADD:
  - Drives the ADD function: zx=nx=zy=ny=0, f=1, no=0.
  - alu_x=acc, alu_y=mcand.
  - If mplier[0]=1: acc<=alu_out. Otherwise acc holds.
  - Next state: DBL.
- DBL:
  - ADD function; alu_x=alu_y=mcand; mcand<=alu_out (mcand<<1 mod 2^16).
  - mplier<=mplier>>1 (logical).
  - Next = ((mplier>>1)==0) ? DONE : ADD.
- DONE:
  - result<=acc; done=1 for this cycle only; ALU controls = ZERO function.
  - Next state: IDLE. start is ignored in DONE.
- busy=1 exactly in ADD and DBL. start while busy or in DONE is ignored (not queued).
- Latency, with start accepted at edge T:
  - k = position of highest set bit of b, plus 1 (k=0 when b=0).
  - done is high in the cycle after edge T+1+2k. Minimum 1 cycle (b=0), maximum 33 cycles (b[15]=1).
  - The next start is accepted in the cycle after DONE. Back-to-back throughput is therefore latency+1.
- Arithmetic:
  - Modulo 2^16; overflow is silently discarded and no flag is produced.
  - Low 16 bits are identical for signed two's-complement and unsigned operands, so one mode serves both.
- Outputs:
  - alu_* outputs are combinational from state and registers; no glitch requirements beyond synchronous use.
  - result is stable between done pulses. a/b may change freely after the accepting edge.

Test Plan:
- Reset, then start with a=0x1234, b=0x0000 at edge T:
  - done high in cycle after T+1, result=0x0000.
  - busy never asserted; ALU controls show 1,0,1,0,1,0 throughout.
- a=3, b=5:
  - busy for 6 cycles, acc updates only in the ADD cycles for bits 0 and 2.
  - done after T+7, result=0x000F.
- a=0xFFFD (-3), b=7: done after T+7, result=0xFFEB (-21).
- a=300, b=300:
  - done after T+1+2*9, result=0x5F90 (90000 mod 65536).
- a=0xFFFF, b=0xFFFF:
  - 32 busy cycles, result=0x0001.
  - start pulses and operand changes during busy are ignored; result unchanged until done.
- Overlap and recovery:
  - Mid-operation rst=1 (a=3, b=0x8000, assert at T+10): next cycle IDLE, busy=0, result=0, no done.
  - A subsequent start with a=2, b=2 yields done after T'+5, result=0x0004.
